mem_wb_stage: RTL and testbench

- Parametrised successor of the pipeline memory stage: data memory plus MEM/WB pipeline register.
- Adds byte/halfword/word loads and stores selected by funct3, load sign/zero extension, and a configurable wait-state FSM that stalls the pipeline.
- Adds a flush input that squashes the M-stage instruction.
- Sits between the execute-stage output register and writeback.

---
 rtl/mem_wb_stage_if.sv | 40 ++++
 rtl/mem_wb_stage.sv | 157 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: M-side request fields, stall back-pressure, W-side results.
// The master drives the M fields; the slave (the stage) returns stall and W.
interface mem_wb_stage_if #(
  parameter int XLEN = 32
);
  logic            flushM;
  logic            regwriteM;
  logic            memwriteM;
  logic            memreadM;
  logic [1:0]      resultsrcM;
  logic [2:0]      funct3M;
  logic [XLEN-1:0] resultM;
  logic [XLEN-1:0] writedataM;
  logic [4:0]      RdM;
  logic [XLEN-1:0] pc4M;
  logic            stallM;
  logic            regwriteW;
  logic [1:0]      resultsrcW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] pc4W;
  logic [XLEN-1:0] resultW;
  logic [XLEN-1:0] ReaddataW;
  logic            misalignW;

  modport master (
    output flushM, regwriteM, memwriteM, memreadM,
    output resultsrcM, funct3M, resultM, writedataM,
    output RdM, pc4M,
    input  stallM, regwriteW, resultsrcW, RdW,
    input  pc4W, resultW, ReaddataW, misalignW
  );

  modport slave (
    input  flushM, regwriteM, memwriteM, memreadM,
    input  resultsrcM, funct3M, resultM, writedataM,
    input  RdM, pc4M,
    output stallM, regwriteW, resultsrcW, RdW,
    output pc4W, resultW, ReaddataW, misalignW
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Data memory with sized loads/stores, wait-state stall FSM and MEM/WB register.
// Define MEM_MISALIGN_CHK_EN to flag and suppress misaligned accesses.
module mem_wb_stage #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input logic           clk,
  input logic           rst,
  mem_wb_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = XLEN / 8;
  localparam logic [3:0] WS_M1 =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state, nstate;
  logic [3:0] cnt, ncnt;
  logic done, access;

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [XLEN-1:0] rdWord, bSh, hSh, ldExt, wd;
  logic [NB-1:0]   be;
  logic            misLd, misSt, memWe;

  assign idx    = bus.resultM[AW+1:2];
  assign lane   = bus.resultM[1:0];
  assign access = bus.memreadM | bus.memwriteM;
  assign rdWord = mem[idx];
  assign bSh    = rdWord >> {lane, 3'b000};
  assign hSh    = rdWord >> {lane[1], 4'b0000};

`ifdef MEM_MISALIGN_CHK_EN
  assign misLd = bus.memreadM &
    ((bus.funct3M[1:0] == 2'b01 & lane[0]) |
     (bus.funct3M[1] & lane != 2'b00));
  assign misSt = bus.memwriteM &
    ((bus.funct3M == 3'b001 & lane[0]) |
     (bus.funct3M == 3'b010 & lane != 2'b00));
`else
  assign misLd = 1'b0;
  assign misSt = 1'b0;
`endif

  always_comb begin
    ldExt = rdWord;
    unique case (bus.funct3M)
      3'b000: ldExt = {{(XLEN-8){bSh[7]}}, bSh[7:0]};
      3'b001: ldExt = {{(XLEN-16){hSh[15]}}, hSh[15:0]};
      3'b100: ldExt = {{(XLEN-8){1'b0}}, bSh[7:0]};
      3'b101: ldExt = {{(XLEN-16){1'b0}}, hSh[15:0]};
      default: ldExt = rdWord;
    endcase
  end

  always_comb begin
    be = '0;
    wd = bus.writedataM;
    unique case (bus.funct3M)
      3'b000: begin
        be = NB'(1) << lane;
        wd = {NB{bus.writedataM[7:0]}};
      end
      3'b001: begin
        be = NB'(3) << {lane[1], 1'b0};
        wd = {(NB/2){bus.writedataM[15:0]}};
      end
      3'b010: be = '1;
      default: be = '0;
    endcase
  end

  // Flush wins over any pending wait and cancels the access outright.
  always_comb begin
    bus.stallM = 1'b0;
    done       = 1'b0;
    nstate     = state;
    ncnt       = cnt;
    if (bus.flushM) begin
      nstate = S_IDLE;
      ncnt   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (access && WAIT_STATES > 0) begin
            bus.stallM = 1'b1;
            ncnt       = WS_M1;
            nstate     = S_WAIT;
          end else begin
            done = 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            bus.stallM = 1'b1;
            ncnt       = cnt - 4'd1;
          end else begin
            done   = 1'b1;
            nstate = S_IDLE;
          end
        end
        default: nstate = S_IDLE;
      endcase
    end
  end

  assign memWe = done & bus.memwriteM & ~misSt;

  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      bus.regwriteW  <= 1'b0;
      bus.resultsrcW <= '0;
      bus.RdW        <= '0;
      bus.pc4W       <= '0;
      bus.resultW    <= '0;
      bus.ReaddataW  <= '0;
      bus.misalignW  <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      if (done) begin
        bus.regwriteW  <= bus.regwriteM & ~misLd;
        bus.resultsrcW <= bus.resultsrcM;
        bus.RdW        <= bus.RdM;
        bus.pc4W       <= bus.pc4M;
        bus.resultW    <= bus.resultM;
        bus.ReaddataW  <= misLd ? '0 : ldExt;
        bus.misalignW  <= misLd | misSt;
      end else begin
        bus.regwriteW  <= 1'b0;
        bus.resultsrcW <= '0;
        bus.RdW        <= '0;
        bus.pc4W       <= '0;
        bus.resultW    <= '0;
        bus.ReaddataW  <= '0;
        bus.misalignW  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: zero-wait and three-wait instances against a
// byte-addressed reference memory model.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.XLEN(32)) ifA ();
  mem_wb_stage_if #(.XLEN(32)) ifB ();

  mem_wb_stage #(.XLEN(32), .DEPTH_WORDS(256), .WAIT_STATES(0))
    dutA (.clk(clk), .rst(rst), .bus(ifA));
  mem_wb_stage #(.XLEN(32), .DEPTH_WORDS(256), .WAIT_STATES(3))
    dutB (.clk(clk), .rst(rst), .bus(ifB));

  typedef struct {
    logic        rw, mw, mr;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, pc4;
    logic [4:0]  rd;
  } mop_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  src;
    logic [4:0]  rd;
    logic [31:0] pc4, res, rdata;
    logic        mis;
  } wout_t;

  typedef struct {
    int    stalls;
    bit    bubblesOk;
    bit    timeout;
    wout_t w;
  } obs_t;

  logic [7:0] mdl [2][1024];
  int nChecks = 0;
  int nFail = 0;

  function automatic mop_t mkOp(logic rw, logic mw, logic mr,
      logic [1:0] src, logic [2:0] f3, logic [31:0] addr,
      logic [31:0] wdata, logic [4:0] rd, logic [31:0] pc4);
    mop_t m;
    m.rw = rw; m.mw = mw; m.mr = mr; m.src = src; m.f3 = f3;
    m.addr = addr; m.wdata = wdata; m.rd = rd; m.pc4 = pc4;
    return m;
  endfunction

  function automatic bit isMis(mop_t m);
`ifdef MEM_MISALIGN_CHK_EN
    bit half, word;
    if (m.mr) begin
      half = m.f3 inside {3'd1, 3'd5};
      word = m.f3 inside {3'd2, 3'd3, 3'd6, 3'd7};
    end else if (m.mw) begin
      half = (m.f3 == 3'd1);
      word = (m.f3 == 3'd2);
    end else begin
      return 1'b0;
    end
    return (half && m.addr[0]) || (word && m.addr[1:0] != 2'b00);
`else
    return (m.mr & 1'b0);
`endif
  endfunction

  function automatic logic [31:0] expLoad(int id, mop_t m);
    int a, h, w;
    logic [15:0] hv;
    logic [31:0] wv;
    a = int'(m.addr[9:0]);
    h = a & ~1;
    w = a & ~3;
    hv = {mdl[id][h+1], mdl[id][h]};
    wv = {mdl[id][w+3], mdl[id][w+2], mdl[id][w+1], mdl[id][w]};
    if (isMis(m)) return 32'h0;
    case (m.f3)
      3'd0: return 32'($signed(mdl[id][a]));
      3'd1: return 32'($signed(hv));
      3'd4: return 32'(mdl[id][a]);
      3'd5: return 32'(hv);
      default: return wv;
    endcase
  endfunction

  function automatic void modelStore(int id, mop_t m);
    int a, h, w;
    a = int'(m.addr[9:0]);
    h = a & ~1;
    w = a & ~3;
    if (!m.mw || isMis(m)) return;
    case (m.f3)
      3'd0: mdl[id][a] = m.wdata[7:0];
      3'd1: begin
        mdl[id][h] = m.wdata[7:0];
        mdl[id][h+1] = m.wdata[15:8];
      end
      3'd2: for (int k = 0; k < 4; k++) mdl[id][w+k] = m.wdata[8*k +: 8];
      default: ;
    endcase
  endfunction

  function automatic wout_t expW(int id, mop_t m);
    wout_t e;
    e.rw = m.rw & ~(m.mr & isMis(m));
    e.src = m.src;
    e.rd = m.rd;
    e.pc4 = m.pc4;
    e.res = m.addr;
    e.rdata = m.mr ? expLoad(id, m) : 32'h0;
    e.mis = isMis(m);
    return e;
  endfunction

  function automatic wout_t getW(int id);
    wout_t g;
    if (id == 0) g = {ifA.regwriteW, ifA.resultsrcW, ifA.RdW, ifA.pc4W,
                      ifA.resultW, ifA.ReaddataW, ifA.misalignW};
    else g = {ifB.regwriteW, ifB.resultsrcW, ifB.RdW, ifB.pc4W,
              ifB.resultW, ifB.ReaddataW, ifB.misalignW};
    return g;
  endfunction

  function automatic logic getStall(int id);
    return (id == 0) ? ifA.stallM : ifB.stallM;
  endfunction

  task automatic drive(int id, mop_t m);
    if (id == 0) begin
      ifA.regwriteM = m.rw; ifA.memwriteM = m.mw; ifA.memreadM = m.mr;
      ifA.resultsrcM = m.src; ifA.funct3M = m.f3; ifA.resultM = m.addr;
      ifA.writedataM = m.wdata; ifA.RdM = m.rd; ifA.pc4M = m.pc4;
    end else begin
      ifB.regwriteM = m.rw; ifB.memwriteM = m.mw; ifB.memreadM = m.mr;
      ifB.resultsrcM = m.src; ifB.funct3M = m.f3; ifB.resultM = m.addr;
      ifB.writedataM = m.wdata; ifB.RdM = m.rd; ifB.pc4M = m.pc4;
    end
  endtask

  // Starts at a negedge; holds the op until it completes, ends at a negedge.
  task automatic issue(int id, mop_t m, output obs_t o);
    logic s;
    wout_t w;
    o.stalls = 0; o.bubblesOk = 1'b1; o.timeout = 1'b1; o.w = '0;
    drive(id, m);
    for (int c = 0; c < 20; c++) begin
      #1 s = getStall(id);
      @(posedge clk);
      #1 w = getW(id);
      if (s === 1'b1) begin
        o.stalls++;
        if (w.rw !== 1'b0 || w.rd !== 5'd0) o.bubblesOk = 1'b0;
      end else begin
        o.w = w;
        o.timeout = 1'b0;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    drive(id, mkOp(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    nChecks++;
    if (getW(0) !== '0) begin
      nFail++; $display("FAIL reset_wA got=%h exp=0", getW(0));
    end
    nChecks++;
    if (getW(1) !== '0) begin
      nFail++; $display("FAIL reset_wB got=%h exp=0", getW(1));
    end
    nChecks++;
    if (ifA.stallM !== 1'b0) begin
      nFail++; $display("FAIL reset_stallA got=%b exp=0", ifA.stallM);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    obs_t o;
    mop_t m;
    for (int w = 0; w < 64; w++) begin
      for (int id = 0; id < 2; id++) begin
        m = mkOp(0, 1, 0, 0, 3'd2, 32'(w * 4), $urandom, 0, 0);
        issue(id, m, o);
        modelStore(id, m);
        nChecks++;
        if (o.timeout || o.stalls !== (id == 0 ? 0 : 3)) begin
          nFail++;
          $display("FAIL fill_stalls id=%0d got=%0d exp=%0d to=%b",
                   id, o.stalls, (id == 0 ? 0 : 3), o.timeout);
        end
      end
    end
  endtask

  task automatic test_sized_access();
    obs_t o;
    mop_t m;
    mop_t ops [13];
    logic [31:0] expv [13];
    ops[0]  = mkOp(0, 1, 0, 0, 3'd2, 32'h10, 32'hDEADBEEF, 0, 32'h4);
    ops[1]  = mkOp(1, 0, 1, 1, 3'd2, 32'h10, 0, 5'd3, 32'h8);
    ops[2]  = mkOp(0, 1, 0, 0, 3'd2, 32'h20, 32'h80FF7F01, 0, 0);
    ops[3]  = mkOp(1, 0, 1, 1, 3'd0, 32'h23, 0, 5'd4, 0);
    ops[4]  = mkOp(1, 0, 1, 1, 3'd4, 32'h23, 0, 5'd5, 0);
    ops[5]  = mkOp(1, 0, 1, 1, 3'd1, 32'h22, 0, 5'd6, 0);
    ops[6]  = mkOp(1, 0, 1, 1, 3'd5, 32'h20, 0, 5'd7, 0);
    ops[7]  = mkOp(0, 1, 0, 0, 3'd2, 32'h30, 32'h11223344, 0, 0);
    ops[8]  = mkOp(0, 1, 0, 0, 3'd0, 32'h31, 32'h555555AA, 0, 0);
    ops[9]  = mkOp(1, 0, 1, 1, 3'd2, 32'h30, 0, 5'd8, 0);
    ops[10] = mkOp(0, 1, 0, 0, 3'd1, 32'h32, 32'h1234BEEF, 0, 0);
    ops[11] = mkOp(1, 0, 1, 1, 3'd2, 32'h30, 0, 5'd9, 0);
    ops[12] = mkOp(1, 0, 1, 1, 3'd2, 32'h430, 0, 5'd10, 0);
    expv = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hFFFFFF80, 32'h00000080,
             32'hFFFF80FF, 32'h00007F01, 32'h0, 32'h0, 32'h1122AA44,
             32'h0, 32'hBEEFAA44, 32'hBEEFAA44};
    for (int i = 0; i < 13; i++) begin
      m = ops[i];
      issue(0, m, o);
      modelStore(0, m);
      nChecks++;
      if (o.timeout || o.stalls !== 0) begin
        nFail++; $display("FAIL sized_stall op=%0d got=%0d exp=0", i, o.stalls);
      end
      if (m.mr) begin
        nChecks++;
        if (o.w.rdata !== expv[i] || o.w.rw !== 1'b1 || o.w.rd !== m.rd) begin
          nFail++;
          $display("FAIL sized_load op=%0d got=%h rw=%b exp=%h rw=1",
                   i, o.w.rdata, o.w.rw, expv[i]);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    obs_t o;
    mop_t m;
    m = mkOp(1, 0, 1, 1, 3'd2, 32'h30, 0, 5'd11, 32'h200);
    issue(1, m, o);
    nChecks++;
    if (o.timeout || o.stalls !== 3 || !o.bubblesOk) begin
      nFail++;
      $display("FAIL wait_lw stalls got=%0d bub=%b exp=3 bub=1",
               o.stalls, o.bubblesOk);
    end
    nChecks++;
    if (o.w !== expW(1, m)) begin
      nFail++; $display("FAIL wait_lw_w got=%h exp=%h", o.w, expW(1, m));
    end
    m = mkOp(1, 0, 0, 0, 3'd0, 32'h12345, 0, 5'd12, 32'h204);
    issue(1, m, o);
    nChecks++;
    if (o.timeout || o.stalls !== 0 || o.w !== expW(1, m)) begin
      nFail++;
      $display("FAIL wait_alu stalls=%0d got=%h exp=%h",
               o.stalls, o.w, expW(1, m));
    end
  endtask

  task automatic test_flush();
    obs_t o;
    mop_t m;
    wout_t w;
    m = mkOp(0, 1, 0, 0, 3'd2, 32'h40, 32'h12345678, 0, 0);
    drive(1, m);
    #1;
    nChecks++;
    if (ifB.stallM !== 1'b1) begin
      nFail++; $display("FAIL flush_stall1 got=%b exp=1", ifB.stallM);
    end
    @(posedge clk);
    @(negedge clk);
    ifB.flushM = 1'b1;
    #1;
    nChecks++;
    if (ifB.stallM !== 1'b0) begin
      nFail++; $display("FAIL flush_stall_drop got=%b exp=0", ifB.stallM);
    end
    @(posedge clk);
    #1 w = getW(1);
    nChecks++;
    if (w.rw !== 1'b0 || w.rd !== 5'd0) begin
      nFail++; $display("FAIL flush_bubble got rw=%b rd=%0d exp 0 0", w.rw, w.rd);
    end
    @(negedge clk);
    ifB.flushM = 1'b0;
    drive(1, mkOp(0, 0, 0, 0, 0, 0, 0, 0, 0));
    m = mkOp(1, 0, 1, 1, 3'd2, 32'h40, 0, 5'd13, 0);
    issue(1, m, o);
    nChecks++;
    if (o.timeout || o.w.rdata !== expLoad(1, m)) begin
      nFail++;
      $display("FAIL flush_nowrite got=%h exp=%h", o.w.rdata, expLoad(1, m));
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    mop_t m;
    m = mkOp(1, 0, 0, 2, 3'd0, 32'hABCD, 0, 5'd7, 32'h300);
    issue(1, m, o);
    nChecks++;
    if (o.timeout || o.w.rd !== 5'd7 || o.w.rw !== 1'b1) begin
      nFail++; $display("FAIL rstwait_pre got rd=%0d exp=7", o.w.rd);
    end
    m = mkOp(0, 1, 0, 0, 3'd2, 32'h44, 32'hCAFEF00D, 0, 0);
    drive(1, m);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    nChecks++;
    if (getW(1) !== '0) begin
      nFail++; $display("FAIL rstwait_w got=%h exp=0", getW(1));
    end
    drive(1, mkOp(0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m = mkOp(1, 0, 1, 1, 3'd2, 32'h44, 0, 5'd14, 0);
    issue(1, m, o);
    nChecks++;
    if (o.timeout || o.w.rdata !== expLoad(1, m)) begin
      nFail++;
      $display("FAIL rstwait_nowrite got=%h exp=%h", o.w.rdata, expLoad(1, m));
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    mop_t m;
    m = mkOp(1, 0, 1, 1, 3'd2, 32'h42, 0, 5'd15, 0);
    issue(0, m, o);
    nChecks++;
    if (o.w !== expW(0, m)) begin
      nFail++; $display("FAIL mis_lw got=%h exp=%h", o.w, expW(0, m));
    end
`ifdef MEM_MISALIGN_CHK_EN
    nChecks++;
    if (o.w.mis !== 1'b1 || o.w.rw !== 1'b0 || o.w.rdata !== 32'h0) begin
      nFail++;
      $display("FAIL mis_lw_flag got mis=%b rw=%b d=%h exp 1 0 0",
               o.w.mis, o.w.rw, o.w.rdata);
    end
`endif
    m = mkOp(0, 1, 0, 0, 3'd1, 32'h41, 32'h0000BEEF, 0, 0);
    issue(0, m, o);
    modelStore(0, m);
    m = mkOp(1, 0, 1, 1, 3'd2, 32'h40, 0, 5'd16, 0);
    issue(0, m, o);
    nChecks++;
    if (o.w.rdata !== expLoad(0, m)) begin
      nFail++; $display("FAIL mis_sh_mem got=%h exp=%h", o.w.rdata, expLoad(0, m));
    end
    m = mkOp(1, 0, 1, 1, 3'd2, 32'h42, 0, 5'd17, 0);
    issue(1, m, o);
    nChecks++;
    if (o.timeout || o.stalls !== 3 || o.w !== expW(1, m)) begin
      nFail++;
      $display("FAIL mis_wait stalls=%0d got=%h exp=%h",
               o.stalls, o.w, expW(1, m));
    end
  endtask

  task automatic test_random(int id, int n);
    obs_t o;
    mop_t m;
    wout_t g;
    int kind;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 2);
      m.addr = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 255));
      m.wdata = $urandom;
      m.pc4 = $urandom;
      m.rd = 5'($urandom_range(0, 31));
      m.f3 = 3'($urandom_range(0, 7));
      m.rw = 1'($urandom_range(0, 1));
      m.mr = (kind == 1);
      m.mw = (kind == 2);
      m.src = (kind == 1) ? 2'b01 : ($urandom_range(0, 1) ? 2'b10 : 2'b00);
      if (kind == 2) m.rw = 1'b0;
      issue(id, m, o);
      nChecks++;
      if (o.timeout || !o.bubblesOk ||
          o.stalls !== ((id == 1 && kind != 0) ? 3 : 0)) begin
        nFail++;
        $display("FAIL rand_stall id=%0d i=%0d got=%0d bub=%b to=%b",
                 id, i, o.stalls, o.bubblesOk, o.timeout);
      end
      g = o.w;
      if (!m.mr) g.rdata = 32'h0;
      nChecks++;
      if (g !== expW(id, m)) begin
        nFail++;
        $display("FAIL rand_w id=%0d i=%0d f3=%0d got=%h exp=%h",
                 id, i, m.f3, g, expW(id, m));
      end
      modelStore(id, m);
    end
  endtask

  initial begin
    ifA.flushM = 1'b0;
    ifB.flushM = 1'b0;
    drive(0, mkOp(0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(1, mkOp(0, 0, 0, 0, 0, 0, 0, 0, 0));
    test_reset();
    test_fill();
    test_sized_access();
    test_wait_states();
    test_flush();
    test_reset_mid_wait();
    test_misalign();
    test_random(0, 300);
    test_random(1, 60);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end
endmodule
